// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and constants for the note sequencer.
//   state_t   - sequencer FSM states
//   phase_t   - which generator register the current write targets
//   NOTE_ADDR_DEF / VOL_ADDR_DEF - default generator register addresses
//   *_MSB / *_LSB - bit fields of a 10-bit step-table entry {volume, note}
package note_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        WAIT
    } state_t;

    typedef enum logic {
        NOTE,
        VOL
    } phase_t;

    localparam logic [2:0] NOTE_ADDR_DEF = 3'd0;
    localparam logic [2:0] VOL_ADDR_DEF  = 3'd1;

    localparam int ENTRY_W  = 10;
    localparam int VOL_MSB  = 9;
    localparam int VOL_LSB  = 5;
    localparam int NOTE_MSB = 4;
    localparam int NOTE_LSB = 0;

endpackage

// File: rtl/note_sequencer_step_table.sv
// step_table: DEPTH x ENTRY_W register file holding {volume, note} steps.
//   clk, rst   - clock, synchronous active-high clear of every entry
//   en         - clock enable; writes are ignored while low
//   we, wr_idx, wr_data - synchronous write port
//   rd_idx, rd_data     - combinational read port (returns pre-write contents
//                         in the cycle of a same-index write)
module step_table
    import note_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [ENTRY_W-1:0]       rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en && we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays a step table into signal_generator's register port.
// Each tempo step issues two register writes (note, then volume), each made
// of one setup cycle, STROBE_LEN strobe cycles and one hold cycle.
//   clk, rst     - clock, synchronous active-high reset
//   en           - clock enable; all state and outputs hold while low
//   load_we, load_idx, load_data - step-table write port ({vol, note})
//   run          - level; play while high, stop after the current burst
//   seq_len      - index of the last step before wrapping to 0
//   tempo        - step period is (tempo+1)*PRESCALE cycles
//   write_strobe, address, data - generator register-write port
//   busy         - high whenever the FSM is not IDLE
//   step_idx     - step currently playing
//   step_pulse   - one-cycle pulse in the first cycle of each burst
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int         DEPTH      = 16,
    parameter int         STROBE_LEN = 2,
    parameter int         PRESCALE   = 4,
    parameter logic [2:0] NOTE_ADDR  = NOTE_ADDR_DEF,
    parameter logic [2:0] VOL_ADDR   = VOL_ADDR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [ENTRY_W-1:0]       load_data,
    input  logic                     run,
    input  logic [$clog2(DEPTH)-1:0] seq_len,
    input  logic [7:0]               tempo,
    output logic                     write_strobe,
    output logic [2:0]               address,
    output logic [4:0]               data,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     step_pulse
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(256 * PRESCALE);
    localparam int SCNT_W = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
    localparam int FLD_W  = VOL_MSB - VOL_LSB + 1;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    // Counter reload value: one less than the step period, so the counter
    // reaches zero in the last cycle of the period.
    function automatic logic [CNT_W-1:0] period_last(input logic [7:0] t);
        return CNT_W'((32'(t) + 32'd1) * 32'(PRESCALE) - 32'd1);
    endfunction

    state_t            state, state_n;
    phase_t            phase, phase_n;
    logic [SCNT_W-1:0] scnt, scnt_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]  period, period_n;
    logic [IDX_W-1:0]  idx_n, next_idx, rd_idx;
    logic [FLD_W-1:0]  vol_q, vol_n;
    logic [ENTRY_W-1:0] rd_data;
    logic              strobe_n, pulse_n, start;
    logic [2:0]        addr_n;
    logic [4:0]        data_n;

    step_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .we      (load_we),
        .wr_idx  (load_idx),
        .wr_data (load_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // The table is read for the step about to start: step 0 from IDLE,
    // otherwise the successor of the current step. Using >= lets a seq_len
    // lowered below the playing index wrap straight back to 0.
    always_comb begin
        next_idx = (step_idx >= seq_len) ? '0 : step_idx + IDX_W'(1);
        rd_idx   = (state == IDLE) ? '0 : next_idx;
    end

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        scnt_n   = scnt;
        cnt_n    = sat_dec(cnt);
        period_n = period;
        idx_n    = step_idx;
        vol_n    = vol_q;
        strobe_n = 1'b0;
        addr_n   = address;
        data_n   = data;
        pulse_n  = 1'b0;
        start    = 1'b0;

        unique case (state)
            IDLE: begin
                if (run) begin
                    // tempo is captured only here; later steps reuse it
                    period_n = period_last(tempo);
                    start    = 1'b1;
                end
            end
            SETUP: begin
                state_n  = STROBE;
                strobe_n = 1'b1;
                scnt_n   = SCNT_W'(STROBE_LEN - 1);
            end
            STROBE: begin
                if (scnt == '0) begin
                    state_n = HOLD;
                end else begin
                    scnt_n   = scnt - SCNT_W'(1);
                    strobe_n = 1'b1;
                end
            end
            HOLD: begin
                if (phase == NOTE) begin
                    phase_n = VOL;
                    state_n = SETUP;
                    addr_n  = VOL_ADDR;
                    data_n  = vol_q;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (!run) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    start = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Burst start: the note goes out immediately, so only the volume
        // field needs holding until the second write.
        if (start) begin
            state_n = SETUP;
            phase_n = NOTE;
            idx_n   = rd_idx;
            vol_n   = rd_data[VOL_MSB:VOL_LSB];
            addr_n  = NOTE_ADDR;
            data_n  = rd_data[NOTE_MSB:NOTE_LSB];
            pulse_n = 1'b1;
            cnt_n   = period_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= NOTE;
            scnt         <= '0;
            cnt          <= '0;
            period       <= '0;
            vol_q        <= '0;
            step_idx     <= '0;
            write_strobe <= 1'b0;
            address      <= '0;
            data         <= '0;
            busy         <= 1'b0;
            step_pulse   <= 1'b0;
        end else if (en) begin
            state        <= state_n;
            phase        <= phase_n;
            scnt         <= scnt_n;
            cnt          <= cnt_n;
            period       <= period_n;
            vol_q        <= vol_n;
            step_idx     <= idx_n;
            write_strobe <= strobe_n;
            address      <= addr_n;
            data         <= data_n;
            busy         <= (state_n != IDLE);
            step_pulse   <= pulse_n;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed plus randomized stimulus for note_sequencer,
// checked every cycle against a burst-position reference model.
module tb_note_sequencer;

    localparam int SL  = 2;
    localparam int PRE = 4;
    localparam int L   = SL + 2;
    localparam int B   = 2 * L;

    logic       clk = 1'b0;
    logic       rst, en, load_we, run;
    logic [3:0] load_idx, seq_len;
    logic [9:0] load_data;
    logic [7:0] tempo;
    logic       write_strobe, busy, step_pulse;
    logic [2:0] address;
    logic [4:0] data;
    logic [3:0] step_idx;

    always #5 clk = ~clk;

    note_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .load_we      (load_we),
        .load_idx     (load_idx),
        .load_data    (load_data),
        .run          (run),
        .seq_len      (seq_len),
        .tempo        (tempo),
        .write_strobe (write_strobe),
        .address      (address),
        .data         (data),
        .busy         (busy),
        .step_idx     (step_idx),
        .step_pulse   (step_pulse)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: position m_t counts cycles since the burst began.
    bit         m_busy  = 1'b0;
    bit         m_pulse = 1'b0;
    int         m_t     = 0;
    int         m_P     = 0;
    logic [3:0] m_idx   = '0;
    logic [9:0] m_entry = '0;
    logic [9:0] m_tab [16];
    logic [2:0] m_addr  = '0;
    logic [4:0] m_data  = '0;
    logic       exp_strobe;

    function void m_start(input logic [3:0] i);
        m_busy  = 1'b1;
        m_t     = 0;
        m_idx   = i;
        m_pulse = 1'b1;
        m_entry = m_tab[i];
    endfunction

    function void model_edge();
        if (rst) begin
            m_busy  = 1'b0;
            m_pulse = 1'b0;
            m_t     = 0;
            m_idx   = '0;
            m_addr  = '0;
            m_data  = '0;
            for (int i = 0; i < 16; i++) m_tab[i] = '0;
            return;
        end
        if (!en) return;
        m_pulse = 1'b0;
        if (!m_busy) begin
            if (run) begin
                m_P = (int'(tempo) + 1) * PRE;
                m_start(4'd0);
            end
        end else if (m_t >= B) begin
            if (!run) m_busy = 1'b0;
            else if (m_t >= m_P - 1) m_start((m_idx >= seq_len) ? 4'd0 : m_idx + 4'd1);
            else m_t++;
        end else begin
            m_t++;
        end
        if (load_we) m_tab[load_idx] = load_data;
        if (m_busy && m_t < B) begin
            m_addr = (m_t / L == 0) ? 3'd0 : 3'd1;
            m_data = (m_t / L == 0) ? m_entry[4:0] : m_entry[9:5];
        end
    endfunction

    task automatic check_outputs();
        exp_strobe = m_busy && (m_t < B) && ((m_t % L) >= 1) && ((m_t % L) <= SL);
        checks++;
        assert (write_strobe === exp_strobe) else begin
            errors++;
            $error("FAIL strobe cyc=%0d observed=%b expected=%b", cyc, write_strobe, exp_strobe);
        end
        checks++;
        assert (address === m_addr) else begin
            errors++;
            $error("FAIL address cyc=%0d observed=%0d expected=%0d", cyc, address, m_addr);
        end
        checks++;
        assert (data === m_data) else begin
            errors++;
            $error("FAIL data cyc=%0d observed=%0d expected=%0d", cyc, data, m_data);
        end
        checks++;
        assert (busy === m_busy) else begin
            errors++;
            $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, m_busy);
        end
        checks++;
        assert (step_idx === m_idx) else begin
            errors++;
            $error("FAIL step_idx cyc=%0d observed=%0d expected=%0d", cyc, step_idx, m_idx);
        end
        checks++;
        assert (step_pulse === m_pulse) else begin
            errors++;
            $error("FAIL step_pulse cyc=%0d observed=%b expected=%b", cyc, step_pulse, m_pulse);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs();
    endtask

    // Advance until the model sits at burst position tgt_t (optionally of a
    // given step); a missed target within the budget counts as a failure.
    task automatic wait_pos(input int tgt_t, input int tgt_idx, input int limit);
        bit hit = 1'b0;
        for (int n = 0; n < limit && !hit; n++) begin
            tick();
            hit = m_busy && (m_t == tgt_t) && (tgt_idx < 0 || int'(m_idx) == tgt_idx);
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL wait_pos timeout observed=0 expected=1 (t=%0d idx=%0d)", tgt_t, tgt_idx);
        end
    endtask

    bit saw31;

    initial begin
        rst = 1'b1; en = 1'b1; run = 1'b0; load_we = 1'b0;
        load_idx = '0; load_data = '0; seq_len = '0; tempo = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic burst: single step, period 16
        load_we = 1'b1; load_idx = 4'd0; load_data = {5'd20, 5'd7};
        tick();
        load_we = 1'b0; seq_len = 4'd0; tempo = 8'd3; run = 1'b1;
        repeat (40) tick();

        // Stop during the first write's strobe
        wait_pos(1, -1, 100);
        run = 1'b0;
        repeat (20) tick();

        // Wrap over three steps with a short period
        for (int i = 0; i < 3; i++) begin
            load_we = 1'b1; load_idx = 4'(i); load_data = {5'(10 + i), 5'(1 + i)};
            tick();
        end
        load_we = 1'b0; seq_len = 4'd2; tempo = 8'd1; run = 1'b1;
        repeat (45) tick();

        // Concurrent load of the step that is playing
        wait_pos(2, 1, 100);
        load_we = 1'b1; load_idx = 4'd1; load_data = {5'd9, 5'd31};
        tick();
        load_we = 1'b0;
        saw31 = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (write_strobe && address == 3'd0 && data == 5'd31 && step_idx == 4'd1) saw31 = 1'b1;
        end
        checks++;
        assert (saw31 === 1'b1) else begin
            errors++;
            $error("FAIL reload_note observed=%b expected=1", saw31);
        end

        // Enable freeze during strobe
        wait_pos(1, -1, 100);
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        repeat (20) tick();

        // Reset during strobe, run stays high
        wait_pos(2, -1, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (25) tick();

        // Randomized traffic
        seq_len = 4'd3;
        for (int n = 0; n < 900; n++) begin
            en      = ($urandom_range(0, 7) != 0);
            rst     = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            load_we   = ($urandom_range(0, 5) == 0);
            load_idx  = 4'($urandom_range(0, 15));
            load_data = 10'($urandom);
            if ($urandom_range(0, 59) == 0) seq_len = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 29) == 0) tempo = 8'($urandom_range(0, 4));
            tick();
        end
        rst = 1'b0; en = 1'b1; load_we = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
